// File: rtl/pipe_pkg.sv
// Shared definitions for the centre-search pipeline.
//   N_SENTINEL    : centre id meaning "no centre found on this lane"
//   STAGE_COLLECT : stage code for the collect phase
//   STAGE_FINISH  : stage code for the finish phase
//   rec_t         : one collected record {lane, id, dnorm}; fields are sized
//                   for the widest supported configuration and narrowed by users
//   state_e       : collector FSM states
//   sat_add16     : 16-bit saturating add used by the hit counter
package pipe_pkg;

  localparam int unsigned N_SENTINEL = 4096;
  localparam logic [2:0]  STAGE_COLLECT = 3'd6;
  localparam logic [2:0]  STAGE_FINISH  = 3'd7;

  localparam int unsigned REC_LANE_W = 8;
  localparam int unsigned REC_DATA_W = 32;

  typedef struct packed {
    logic [REC_LANE_W-1:0] lane;
    logic [REC_DATA_W-1:0] id;
    logic [REC_DATA_W-1:0] dnorm;
  } rec_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[16]) begin
      return 16'hFFFF;
    end else begin
      return sum[15:0];
    end
  endfunction

endpackage

// File: rtl/multi_push_fifo.sv
// Multi-write, single-read record FIFO.
//   clk, rst_n   : clock and asynchronous active-low reset (pointers only)
//   push_req_i   : per-port write request, ports served in ascending order
//   push_rec_i   : per-port record
//   push_acc_o   : per-port "written" indication (drops are req & ~acc)
//   pop_i        : consumer pop request, ignored while empty
//   empty_o      : no entry stored
//   head_o       : oldest entry, all zeros while empty
module multi_push_fifo
  import pipe_pkg::*;
#(
  parameter int unsigned PARALLEL = 2,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PARALLEL-1:0] push_req_i,
  input  rec_t [PARALLEL-1:0] push_rec_i,
  output logic [PARALLEL-1:0] push_acc_o,
  input  logic                pop_i,
  output logic                empty_o,
  output rec_t                head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  rec_t          mem_q [DEPTH];
  rec_t          mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] occ_s, free_s, wcnt_s, waddr_s;
  logic          full_s, empty_s, pop_s;
  logic [PARALLEL-1:0] acc_s;
  rec_t          head_s;

  // Free space is taken from occupancy before this cycle's pop, so a pop never
  // makes room for a same-cycle push. Accepted pushes pack contiguously.
  always_comb begin
    full_s  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    empty_s = (wptr_q == rptr_q);
    occ_s   = wptr_q - rptr_q;
    if (full_s) begin
      free_s = '0;
    end else begin
      free_s = PW'(DEPTH) - occ_s;
    end
    mem_d   = mem_q;
    wcnt_s  = '0;
    waddr_s = '0;
    acc_s   = '0;
    for (int k = 0; k < PARALLEL; k++) begin
      if (push_req_i[k] && (wcnt_s < free_s)) begin
        waddr_s = wptr_q + wcnt_s;
        mem_d[waddr_s[AW-1:0]] = push_rec_i[k];
        acc_s[k] = 1'b1;
        wcnt_s   = wcnt_s + PW'(1);
      end else begin
        acc_s[k] = 1'b0;
      end
    end
    wptr_d = wptr_q + wcnt_s;
    pop_s  = pop_i && !empty_s;
    if (pop_s) begin
      rptr_d = rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    if (empty_s) begin
      head_s = '0;
    end else begin
      head_s = mem_q[rptr_q[AW-1:0]];
    end
  end

  // Storage carries no reset; validity comes from the pointers alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  assign push_acc_o = acc_s;
  assign empty_o    = empty_s;
  assign head_o     = head_s;

endmodule

// File: rtl/pipe_stage3_collect.sv
// Stage-3 hit collector: gathers per-lane centre hits during the collect
// phase, queues them as records and streams them to a valid/ready consumer.
//   clk, rst      : clock, asynchronous active-low reset
//   stage         : pipeline stage code (6 collect, 7 finish)
//   center_ids_i  : per-lane centre id, N when the lane has no hit
//   dnorm_i       : per-lane fp16 similarity
//   out_valid/out_ready/out_id/out_dnorm/out_lane : record stream
//   hit_count     : accepted hits this run (saturating)
//   overflow      : sticky, a hit was dropped this run
//   done          : run finished and queue drained
module pipe_stage3_collect
  import pipe_pkg::*;
#(
  parameter int unsigned N        = N_SENTINEL,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PARALLEL = 2,
  parameter int unsigned DEPTH    = 8,
  localparam int unsigned LW      = (PARALLEL > 1) ? $clog2(PARALLEL) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [2:0]                     stage,
  input  logic [PARALLEL-1:0][WIDTH-1:0] center_ids_i,
  input  logic [PARALLEL-1:0][WIDTH-1:0] dnorm_i,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_id,
  output logic [WIDTH-1:0]               out_dnorm,
  output logic [LW-1:0]                  out_lane,
  output logic [15:0]                    hit_count,
  output logic                           overflow,
  output logic                           done
);

  state_e              state_q, state_d;
  logic [15:0]         hit_count_q, hit_count_d;
  logic                overflow_q, overflow_d;
  logic [PARALLEL-1:0] hit_req_s, push_acc_s;
  rec_t [PARALLEL-1:0] push_rec_s;
  logic [15:0]         acc_cnt_s;
  logic                dropped_s, empty_s, unused_head_s;
  rec_t                head_s;

  // Hit detection and record formation; lanes are widened into the record.
  always_comb begin
    for (int k = 0; k < PARALLEL; k++) begin
      hit_req_s[k] = (state_q == ST_COLLECT) && (stage == STAGE_COLLECT) &&
                     (center_ids_i[k] != WIDTH'(N));
      push_rec_s[k].lane  = REC_LANE_W'(k);
      push_rec_s[k].id    = REC_DATA_W'(center_ids_i[k]);
      push_rec_s[k].dnorm = REC_DATA_W'(dnorm_i[k]);
    end
  end

  multi_push_fifo #(
    .PARALLEL (PARALLEL),
    .DEPTH    (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .push_req_i (hit_req_s),
    .push_rec_i (push_rec_s),
    .push_acc_o (push_acc_s),
    .pop_i      (out_ready),
    .empty_o    (empty_s),
    .head_o     (head_s)
  );

  // Next-state and counter update logic.
  always_comb begin
    acc_cnt_s = 16'd0;
    for (int k = 0; k < PARALLEL; k++) begin
      acc_cnt_s = acc_cnt_s + {15'd0, push_acc_s[k]};
    end
    dropped_s   = |(hit_req_s & ~push_acc_s);
    state_d     = state_q;
    hit_count_d = hit_count_q;
    overflow_d  = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (stage == STAGE_COLLECT) begin
          // Fresh run: clear statistics, leave any queued records alone.
          state_d     = ST_COLLECT;
          hit_count_d = 16'd0;
          overflow_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        hit_count_d = sat_add16(hit_count_q, acc_cnt_s);
        overflow_d  = overflow_q | dropped_s;
        if (stage == STAGE_FINISH) begin
          state_d = ST_DRAIN;
        end else if (stage != STAGE_COLLECT) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_DRAIN: begin
        if (empty_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (stage != STAGE_FINISH) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and run statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      hit_count_q <= 16'd0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hit_count_q <= hit_count_d;
      overflow_q  <= overflow_d;
    end
  end

  // The FIFO already zeroes its head while empty, so outputs read 0 then.
  assign out_valid     = !empty_s;
  assign out_id        = head_s.id[WIDTH-1:0];
  assign out_dnorm     = head_s.dnorm[WIDTH-1:0];
  assign out_lane      = head_s.lane[LW-1:0];
  assign hit_count     = hit_count_q;
  assign overflow      = overflow_q;
  assign done          = (state_q == ST_DONE) && empty_s;
  assign unused_head_s = ^head_s;

endmodule

// File: tb/tb_pipe_stage3_collect.sv
module tb_pipe_stage3_collect;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [2:0]       stage;
  logic [1:0][15:0] ids;
  logic [1:0][15:0] dn;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_id;
  logic [15:0]      out_dnorm;
  logic [0:0]       out_lane;
  logic [15:0]      hit_count;
  logic             overflow;
  logic             done;

  logic [32:0] sb[$];   // expected {lane, id, dnorm}
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage3_collect dut (
    .clk          (clk),
    .rst          (rst),
    .stage        (stage),
    .center_ids_i (ids),
    .dnorm_i      (dn),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_id       (out_id),
    .out_dnorm    (out_dnorm),
    .out_lane     (out_lane),
    .hit_count    (hit_count),
    .overflow     (overflow),
    .done         (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One cycle of lane inputs; e0/e1 say whether the hit is expected to be stored.
  task automatic hit(input logic h0, input logic [15:0] i0, input logic [15:0] d0,
                     input logic h1, input logic [15:0] i1, input logic [15:0] d1,
                     input logic e0, input logic e1);
    ids[0] = h0 ? i0 : 16'd4096;
    dn[0]  = d0;
    ids[1] = h1 ? i1 : 16'd4096;
    dn[1]  = d1;
    if (e0) sb.push_back({1'b0, i0, d0});
    if (e1) sb.push_back({1'b1, i1, d1});
    @(posedge clk);
    #1;
    ids[0] = 16'd4096;
    ids[1] = 16'd4096;
  endtask

  // Leave the run and enter a fresh collect phase.
  task automatic restart();
    stage = 3'd0;
    idle(1);
    stage = 3'd6;
    idle(1);
    chk("restart_clear", {overflow, hit_count}, 64'd0);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < max) begin
      idle(1);
      n++;
    end
    chk("drain_left", sb.size(), 64'd0);
    chk("drain_valid", out_valid, 64'd0);
  endtask

  // Monitor: pops the scoreboard on each handshake, checks hold and idle-zero.
  initial begin
    logic        prev_stall;
    logic [32:0] held;
    logic [32:0] e;
    prev_stall = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
      end else if (out_valid) begin
        if (prev_stall) chk("hold_stable", {out_lane, out_id, out_dnorm}, held);
        if (out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_record: got id %0h lane %0d expected none", out_id, out_lane);
          end else begin
            e = sb.pop_front();
            chk("record", {out_lane, out_id, out_dnorm}, e);
          end
        end
        prev_stall = !out_ready;
        held       = {out_lane, out_id, out_dnorm};
      end else begin
        chk("idle_zero", {out_lane, out_id, out_dnorm}, 64'd0);
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    stage     = 3'd0;
    ids[0]    = 16'd4096;
    ids[1]    = 16'd4096;
    dn[0]     = 16'd0;
    dn[1]     = 16'd0;
    out_ready = 1'b0;
    #1;
    chk("rst_valid", out_valid, 64'd0);
    chk("rst_done", done, 64'd0);
    chk("rst_hits", hit_count, 64'd0);
    chk("rst_ovf", overflow, 64'd0);
    #11 rst = 1'b1;
    idle(1);

    // basic collect: one hit on lane 0, lane 1 idle
    out_ready = 1'b1;
    restart();
    hit(1'b1, 16'd5, 16'h3BD7, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
    chk("basic_valid", out_valid, 64'd1);
    chk("basic_head", {out_lane, out_id, out_dnorm}, {1'b0, 16'd5, 16'h3BD7});
    chk("basic_hits", hit_count, 64'd1);
    drain(10);

    // dual hit in one cycle, lane order preserved
    restart();
    hit(1'b1, 16'd7, 16'h1111, 1'b1, 16'd9, 16'h2222, 1'b1, 1'b1);
    chk("dual_hits", hit_count, 64'd2);
    drain(10);

    // overflow: 10 hits into 8 entries with no reader
    out_ready = 1'b0;
    restart();
    for (int c = 0; c < 5; c++) begin
      hit(1'b1, 16'(20 + 2 * c), 16'(16'h4000 + c), 1'b1, 16'(21 + 2 * c), 16'(16'h5000 + c),
          (c < 4), (c < 4));
      chk("ovf_flag", overflow, (c == 4) ? 64'd1 : 64'd0);
      chk("ovf_hits", hit_count, (c < 4) ? 64'(2 * c + 2) : 64'd8);
    end

    // backpressure: drain the 8 stored records with out_ready toggling
    begin
      int n = 0;
      while (sb.size() != 0 && n < 60) begin
        out_ready = ~out_ready;
        idle(1);
        n++;
      end
    end
    chk("bp_left", sb.size(), 64'd0);
    out_ready = 1'b1;
    idle(1);
    chk("bp_empty", out_valid, 64'd0);

    // finish: three records queued, then stage 7 with reader enabled
    out_ready = 1'b0;
    restart();
    hit(1'b1, 16'd40, 16'h3C00, 1'b1, 16'd41, 16'h3800, 1'b1, 1'b1);
    hit(1'b1, 16'd42, 16'h3400, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
    chk("fin_hits", hit_count, 64'd3);
    chk("fin_not_done", done, 64'd0);
    stage     = 3'd7;
    out_ready = 1'b1;
    begin
      int n = 0;
      while (!done && n < 20) begin
        idle(1);
        n++;
      end
    end
    chk("fin_done", done, 64'd1);
    chk("fin_drained", sb.size(), 64'd0);
    chk("fin_valid", out_valid, 64'd0);
    idle(1);
    chk("fin_done_hold", done, 64'd1);
    stage = 3'd0;
    idle(1);
    chk("fin_done_clear", done, 64'd0);

    // reset mid-run with four records queued
    out_ready = 1'b0;
    restart();
    hit(1'b1, 16'd50, 16'h1000, 1'b1, 16'd51, 16'h1001, 1'b1, 1'b1);
    hit(1'b1, 16'd52, 16'h1002, 1'b1, 16'd53, 16'h1003, 1'b1, 1'b1);
    chk("mid_hits", hit_count, 64'd4);
    chk("mid_valid", out_valid, 64'd1);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 64'd0);
    chk("mid_rst_hits", hit_count, 64'd0);
    chk("mid_rst_ovf", overflow, 64'd0);
    chk("mid_rst_head", {out_lane, out_id, out_dnorm}, 64'd0);
    sb.delete();
    @(posedge clk);
    #2 rst = 1'b1;
    stage     = 3'd0;
    out_ready = 1'b1;
    idle(3);
    chk("post_rst_valid", out_valid, 64'd0);
    restart();
    hit(1'b0, 16'd0, 16'd0, 1'b1, 16'd60, 16'h2BCD, 1'b0, 1'b1);
    chk("post_rst_hits", hit_count, 64'd1);
    drain(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage3_collect.md
PIPE_STAGE3_COLLECT -- requirements
Module: pipe_stage3_collect

Interface
REQ-001 SHALL have parameters: N, default 4096, the "no centre" sentinel id; WIDTH, default 16, the data width; PARALLEL, default 2, the lane count; DEPTH, default 8, the FIFO entries (a power of two, at least 4).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: the reset, asynchronous and active-low (asserted at 0).
REQ-004 SHALL have port stage, input, 3 bits: the pipeline stage code shared with upstream; 6 = collect, 7 = finish.
REQ-005 SHALL have port center_ids_i, input, PARALLEL x WIDTH: per-lane centre id, equal to N when the lane has no hit.
REQ-006 SHALL have port dnorm_i, input, PARALLEL x WIDTH: per-lane fp16 similarity, meaningful only on a hit.
REQ-007 SHALL have port out_valid, output, 1 bit: a record is presented.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts the record.
REQ-009 SHALL have port out_id, output, WIDTH: the record's centre id.
REQ-010 SHALL have port out_dnorm, output, WIDTH: the record's fp16 similarity.
REQ-011 SHALL have port out_lane, output, clog2(PARALLEL) bits: the source lane.
REQ-012 SHALL have port hit_count, output, 16 bits: hits accepted this run, saturating.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, at least one hit dropped this run.
REQ-014 SHALL have port done, output, 1 bit: the run is complete and all records are drained.

Function
REQ-015 SHALL implement FSM states IDLE, COLLECT, DRAIN and DONE.
- IDLE->COLLECT when stage==6.
- COLLECT->DRAIN when stage==7.
- COLLECT->IDLE when stage is neither 6 nor 7.
- DRAIN->DONE when the FIFO is empty.
- DONE->IDLE when stage!=7.
REQ-016 SHALL treat a lane as a hit in a cycle when the state is COLLECT, stage==6 and center_ids_i[k]!=N.
REQ-017 SHALL push hits into the FIFO in ascending lane order in the same cycle; up to PARALLEL writes per cycle.
REQ-018 SHALL compute free space from the occupancy before any same-cycle pop; a same-cycle pop SHALL NOT create room.
REQ-019 SHALL accept hits in lane order while free space remains; the remaining hits SHALL be dropped and SHALL set overflow.
REQ-020 SHALL increment hit_count by the number of accepted hits, saturating at 16'hFFFF.
REQ-021 SHALL assert out_valid whenever the FIFO is non-empty, in any state.
REQ-022 SHALL drive out_id, out_dnorm and out_lane from the head entry.
REQ-023 SHALL pop the head on a cycle where out_valid and out_ready are both 1.
REQ-024 SHALL hold the head outputs stable while out_valid=1 and out_ready=0.
REQ-025 SHALL have a latency of one cycle: a hit pushed at edge t is visible at the head after edge t when the FIFO was empty.
REQ-026 SHALL use wrap-around read and write pointers of clog2(DEPTH)+1 bits. Full means equal low bits and differing MSB. Empty means equal pointers.
REQ-027 SHALL assert done only in DONE, and only while the FIFO is empty.
REQ-028 SHALL clear hit_count and overflow on the IDLE->COLLECT transition, and leave FIFO contents untouched on that transition.
REQ-029 SHALL drive out_id, out_dnorm and out_lane to 0 when out_valid=0.

Reset
REQ-030 SHALL, on rst=0 and asynchronously, set the state to IDLE, both pointers to 0, hit_count to 0, overflow to 0, out_valid to 0 and done to 0.
REQ-031 SHALL discard FIFO contents on reset mid-run; the outputs SHALL reach their reset values within the same cycle.
REQ-032 SHALL NOT require FIFO storage to be reset.

Structure
REQ-033 SHALL take the sentinel N, the STAGE_COLLECT=3'd6 and STAGE_FINISH=3'd7 constants, and the record typedef {lane, id, dnorm} from a shared pipe_pkg package.
REQ-034 SHALL place the FIFO in one sub-module, multi_push_fifo, with PARALLEL push ports and one pop port; the FSM and counters SHALL stay in the top module.

Verification
REQ-035 SHALL cover basic collect:
- Stimulus: stage 6; lane0 id=5, dnorm=16'h3BD7; lane1 id=4096; out_ready=1.
- Response: one record {lane 0, id 5, 3BD7} with out_valid one cycle later; hit_count=1.
REQ-036 SHALL cover dual hit:
- Stimulus: lanes 0 and 1 ids 7 and 9 in the same cycle.
- Response: records 7 then 9 in order; hit_count=2.
REQ-037 SHALL cover overflow:
- Stimulus: out_ready=0; 5 cycles of dual hits with DEPTH=8.
- Response: 8 records stored; overflow=1 from the fifth cycle; hit_count=8.
REQ-038 SHALL cover backpressure:
- Stimulus: out_ready toggles 0/1 each cycle.
- Response: out_id/out_dnorm stable across the 0 cycles; no record lost or duplicated.
REQ-039 SHALL cover finish:
- Stimulus: stage 6->7 with 3 records queued; out_ready=1.
- Response: done=1 exactly after the third pop; done=0 when stage returns to 0.
REQ-040 SHALL cover reset mid-run:
- Stimulus: rst=0 asynchronously with 4 records queued.
- Response: out_valid=0, hit_count=0 and overflow=0 immediately; no stale record after release.
